chi_txreq_link: RTL and testbench

- CHI link-layer transmit endpoint for the REQ channel: requester side of the RXREQ link that the HN-F receives on.
- Accepts reqflit_t from the upstream request generator over valid/ready and buffers it in a small FIFO.
- Drives TXREQFLIT/TXREQFLITV/TXREQFLITPEND under L-credit control.
- Runs the TX link activation handshake and returns unused credits with LCrdReturn flits on link deactivation.

---
 rtl/chi_txreq_link_pkg.sv | 30 +++
 rtl/chi_link_fifo.sv | 46 ++++
 rtl/chi_txreq_link.sv | 152 +++++++++++++++
 tb/tb_chi_txreq_link.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chi_txreq_link_pkg.sv
// rtl/chi_txreq_link_pkg.sv - CHI REQ flit layout, link-state encoding and LCrdReturn opcode shared by TX/RX link endpoints
package chi_txreq_link_pkg;

    localparam logic [6:0] REQ_LCRD_RETURN = 7'd0;

    typedef struct packed {
        logic [3:0]  qos;
        logic [6:0]  tgt_id;
        logic [6:0]  src_id;
        logic [7:0]  txn_id;
        logic [6:0]  opcode;
        logic [47:0] addr;
    } reqflit_t;

    typedef enum logic [1:0] {
        STOP       = 2'd0,
        ACTIVATE   = 2'd1,
        RUN        = 2'd2,
        DEACTIVATE = 2'd3
    } link_state_e;

    // Credit-return flits carry nothing but the opcode, which is itself zero.
    function automatic reqflit_t lcrd_return_flit();
        reqflit_t f;
        f        = '0;
        f.opcode = REQ_LCRD_RETURN;
        return f;
    endfunction

endpackage

// File: rtl/chi_link_fifo.sv
// rtl/chi_link_fifo.sv - synchronous reqflit_t FIFO, power-of-two depth, extra pointer bit separates full from empty
module chi_link_fifo
    import chi_txreq_link_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic     clock,
    input  logic     reset,
    input  logic     i_push,
    input  reqflit_t i_data,
    input  logic     i_pop,
    output reqflit_t o_data,
    output logic     o_full,
    output logic     o_empty
);
    localparam int AW = $clog2(DEPTH);

    reqflit_t    r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_push;
    logic        w_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/chi_txreq_link.sv
// rtl/chi_txreq_link.sv - CHI REQ TX link endpoint (FIFO, L-credits, activation FSM); CHI_TXREQ_LINK_PERF_EN adds perf counters
module chi_txreq_link
    import chi_txreq_link_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int MAX_CREDITS = 15
)(
    input  logic        clock,
    input  logic        reset,
    input  reqflit_t    req_in,
    input  logic        req_in_valid,
    output logic        req_in_ready,
    input  logic        link_up,
    input  logic        link_down,
    output logic        TXLINKACTIVEREQ,
    input  logic        TXLINKACTIVEACK,
    output reqflit_t    TXREQFLIT,
    output logic        TXREQFLITV,
    output logic        TXREQFLITPEND,
    input  logic        TXREQLCRDV,
    output logic [3:0]  credit_cnt,
    output logic        credit_overflow,
`ifdef CHI_TXREQ_LINK_PERF_EN
    output logic [31:0] perf_flits_sent,
    output logic [31:0] perf_credit_stall,
`endif
    output logic [1:0]  link_state
);
    localparam logic [3:0] LP_MAX_CREDITS = 4'(MAX_CREDITS);

    link_state_e r_state;
    link_state_e w_state_nxt;
    logic [3:0]  r_credit;
    logic        r_overflow;
    logic        r_pend;
    logic        r_flitv;
    reqflit_t    r_flit;

    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_send;
    logic        w_ret;
    logic        w_consume;
    logic        w_pend_nxt;
    logic        w_req_active;
    reqflit_t    w_head;

    assign req_in_ready = (r_state == RUN) && !w_full && !link_down;
    assign w_push       = req_in_valid && req_in_ready;

    // PEND must have been visible the cycle before any flit goes out.
    assign w_send    = (r_state == RUN) && !w_empty && (r_credit != 4'd0) && r_pend;
    assign w_ret     = (r_state == DEACTIVATE) && (r_credit != 4'd0) && r_pend;
    assign w_consume = w_send || w_ret;

    assign w_pend_nxt = ((r_state == RUN) && (!w_empty || w_push)) ||
                        ((r_state == DEACTIVATE) && (r_credit != 4'd0));

    chi_link_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (req_in),
        .i_pop   (w_send),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_req_active = 1'b0;
        case (r_state)
            STOP: begin
                if (link_up && !link_down && !TXLINKACTIVEACK) w_state_nxt = ACTIVATE;
            end
            ACTIVATE: begin
                w_req_active = 1'b1;
                if (TXLINKACTIVEACK) w_state_nxt = RUN;
            end
            RUN: begin
                w_req_active = 1'b1;
                if (link_down && w_empty && !w_send) w_state_nxt = DEACTIVATE;
            end
            DEACTIVATE: begin
                if (!TXLINKACTIVEACK && (r_credit == 4'd0) && !w_ret) w_state_nxt = STOP;
            end
            default: w_state_nxt = STOP;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= STOP;
        else        r_state <= w_state_nxt;
    end

    // A grant and a consumed credit in the same cycle cancel out.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_credit   <= 4'd0;
            r_overflow <= 1'b0;
        end else if (TXREQLCRDV && !w_consume) begin
            if (r_credit == LP_MAX_CREDITS) r_overflow <= 1'b1;
            else                            r_credit   <= r_credit + 4'd1;
        end else if (!TXREQLCRDV && w_consume) begin
            r_credit <= r_credit - 4'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pend  <= 1'b0;
            r_flitv <= 1'b0;
            r_flit  <= '0;
        end else begin
            r_pend  <= w_pend_nxt;
            r_flitv <= w_consume;
            r_flit  <= w_send ? w_head : lcrd_return_flit();
        end
    end

`ifdef CHI_TXREQ_LINK_PERF_EN
    logic [31:0] r_perf_flits;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_perf_flits <= 32'd0;
            r_perf_stall <= 32'd0;
        end else begin
            if (w_send) r_perf_flits <= r_perf_flits + 32'd1;
            if ((r_state == RUN) && !w_empty && (r_credit == 4'd0))
                r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_flits_sent   = r_perf_flits;
    assign perf_credit_stall = r_perf_stall;
`endif

    assign TXLINKACTIVEREQ = w_req_active;
    assign TXREQFLIT       = r_flit;
    assign TXREQFLITV      = r_flitv;
    assign TXREQFLITPEND   = r_pend;
    assign credit_cnt      = r_credit;
    assign credit_overflow = r_overflow;
    assign link_state      = r_state;

endmodule

// File: tb/tb_chi_txreq_link.sv
// tb/tb_chi_txreq_link.sv - self-checking bench for chi_txreq_link: directed scenarios plus randomized traffic vs queue/credit model
module tb_chi_txreq_link;
    import chi_txreq_link_pkg::*;

    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    reqflit_t   req_in = '0;
    logic       req_in_valid = 1'b0;
    logic       req_in_ready;
    logic       link_up = 1'b0;
    logic       link_down = 1'b0;
    logic       txlinkactivereq;
    logic       txlinkactiveack = 1'b0;
    reqflit_t   txreqflit;
    logic       flitv;
    logic       pend;
    logic       lcrdv = 1'b0;
    logic [3:0] credit_cnt;
    logic       credit_overflow;
    logic [1:0] link_state;
`ifdef CHI_TXREQ_LINK_PERF_EN
    logic [31:0] perf_flits_sent;
    logic [31:0] perf_credit_stall;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    chi_txreq_link #(.FIFO_DEPTH(DEPTH), .MAX_CREDITS(15)) dut (
        .clock           (clock),
        .reset           (reset),
        .req_in          (req_in),
        .req_in_valid    (req_in_valid),
        .req_in_ready    (req_in_ready),
        .link_up         (link_up),
        .link_down       (link_down),
        .TXLINKACTIVEREQ (txlinkactivereq),
        .TXLINKACTIVEACK (txlinkactiveack),
        .TXREQFLIT       (txreqflit),
        .TXREQFLITV      (flitv),
        .TXREQFLITPEND   (pend),
        .TXREQLCRDV      (lcrdv),
        .credit_cnt      (credit_cnt),
        .credit_overflow (credit_overflow),
`ifdef CHI_TXREQ_LINK_PERF_EN
        .perf_flits_sent   (perf_flits_sent),
        .perf_credit_stall (perf_credit_stall),
`endif
        .link_state      (link_state)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic reqflit_t mk_flit(input logic [7:0] txn);
        reqflit_t f;
        f.qos    = 4'($urandom);
        f.tgt_id = 7'($urandom);
        f.src_id = 7'($urandom);
        f.txn_id = txn;
        f.opcode = 7'($urandom_range(1, 127));
        f.addr   = {16'($urandom), 32'($urandom)};
        return f;
    endfunction

    task automatic push(input reqflit_t f);
        req_in       = f;
        req_in_valid = 1'b1;
        tick();
        req_in_valid = 1'b0;
    endtask

    task automatic grant(input int n);
        lcrdv = 1'b1;
        repeat (n) tick();
        lcrdv = 1'b0;
    endtask

    task automatic bring_up();
        int n;
        link_down = 1'b0;
        link_up = 1'b1;
        txlinkactiveack = 1'b0;
        n = 0;
        while (!txlinkactivereq && n < 20) begin tick(); n++; end
        txlinkactiveack = 1'b1;
        n = 0;
        while (link_state != 2'd2 && n < 20) begin tick(); n++; end
        checks++;
        if (link_state !== 2'd2) begin
            failures++;
            $display("FAIL bring_up link_state=%0d required=2", link_state);
        end
    endtask

    task automatic test_reset();
        logic [10:0] outs;
        reset = 1'b0;
        repeat (3) tick();
        outs = {txlinkactivereq, flitv, pend, credit_cnt, credit_overflow, link_state, req_in_ready};
        checks++;
        if (outs !== 11'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%b required=0", outs);
        end
        checks++;
        if (txreqflit !== reqflit_t'('0)) begin
            failures++;
            $display("FAIL reset_flit got=%h required=0", txreqflit);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_activation();
        link_up = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({link_state, txlinkactivereq, req_in_ready} !== {2'd1, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL activation_wait i=%0d state=%0d req=%b ready=%b required 1/1/0", i, link_state, txlinkactivereq, req_in_ready);
            end
            tick();
        end
        txlinkactiveack = 1'b1;
        tick();
        #1;
        checks++;
        if ({link_state, txlinkactivereq, req_in_ready} !== {2'd2, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL activation_run state=%0d req=%b ready=%b required 2/1/1", link_state, txlinkactivereq, req_in_ready);
        end
    endtask

    task automatic test_credit_gating();
        reqflit_t f5, f6;
        f5 = mk_flit(8'd5);
        f6 = mk_flit(8'd6);
        push(f5);
        push(f6);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({flitv, pend} !== 2'b01) begin
                failures++;
                $display("FAIL gating_hold i=%0d flitv=%b pend=%b required 0/1", i, flitv, pend);
            end
            tick();
        end
        lcrdv = 1'b1;
        tick();
        lcrdv = 1'b0;
        checks++;
        if ({flitv, credit_cnt} !== {1'b0, 4'd1}) begin
            failures++;
            $display("FAIL gating_credit flitv=%b credit=%0d required 0/1", flitv, credit_cnt);
        end
        tick();
        checks++;
        if ({flitv, credit_cnt} !== {1'b1, 4'd0} || txreqflit !== f5) begin
            failures++;
            $display("FAIL gating_first flitv=%b credit=%0d txn=%0d required 1/0/5", flitv, credit_cnt, txreqflit.txn_id);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (flitv !== 1'b0) begin
                failures++;
                $display("FAIL gating_idle i=%0d flitv=%b required 0", i, flitv);
            end
        end
        grant(1);
        tick();
        checks++;
        if ({flitv, credit_cnt} !== {1'b1, 4'd0} || txreqflit !== f6) begin
            failures++;
            $display("FAIL gating_second flitv=%b credit=%0d txn=%0d required 1/0/6", flitv, credit_cnt, txreqflit.txn_id);
        end
        tick();
    endtask

    task automatic test_streaming();
        reqflit_t fl[4];
        int seen, first;
        grant(4);
        checks++;
        if (credit_cnt !== 4'd4) begin
            failures++;
            $display("FAIL stream_grant credit=%0d required=4", credit_cnt);
        end
        for (int i = 0; i < 4; i++) fl[i] = mk_flit(8'(8'h20 + i));
        seen = 0;
        first = -1;
        for (int c = 0; c < 10; c++) begin
            req_in_valid = (c < 4);
            if (c < 4) req_in = fl[c];
            tick();
            if (flitv) begin
                if (seen == 0) first = c;
                checks++;
                if (seen >= 4 || txreqflit !== fl[seen % 4] || c != first + seen) begin
                    failures++;
                    $display("FAIL stream_order c=%0d seen=%0d txn=%0d", c, seen, txreqflit.txn_id);
                end
                seen++;
            end
        end
        req_in_valid = 1'b0;
        checks++;
        if (seen != 4 || first != 1 || credit_cnt !== 4'd0) begin
            failures++;
            $display("FAIL stream_summary seen=%0d first=%0d credit=%0d required 4/1/0", seen, first, credit_cnt);
        end
        for (int k = 0; k < 5; k++) begin
            fl[k % 4] = mk_flit(8'(8'h30 + k));
            req_in = fl[k % 4];
            req_in_valid = 1'b1;
            #1;
            checks++;
            if (req_in_ready !== (k < 4)) begin
                failures++;
                $display("FAIL fifo_full k=%0d ready=%b required=%b", k, req_in_ready, (k < 4));
            end
            tick();
        end
        req_in_valid = 1'b0;
        seen = 0;
        lcrdv = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c == 4) lcrdv = 1'b0;
            tick();
            if (flitv) begin
                checks++;
                if (txreqflit.txn_id !== 8'(8'h30 + seen)) begin
                    failures++;
                    $display("FAIL full_drain seen=%0d txn=%0d required=%0d", seen, txreqflit.txn_id, 8'h30 + seen);
                end
                seen++;
            end
        end
        lcrdv = 1'b0;
        checks++;
        if (seen != 4 || credit_cnt !== 4'd0) begin
            failures++;
            $display("FAIL full_drain_count seen=%0d credit=%0d required 4/0", seen, credit_cnt);
        end
    endtask

    task automatic test_simultaneous();
        reqflit_t f;
        grant(3);
        f = mk_flit(8'h40);
        push(f);
        lcrdv = 1'b1;
        tick();
        lcrdv = 1'b0;
        checks++;
        if ({flitv, credit_cnt} !== {1'b1, 4'd3} || txreqflit !== f) begin
            failures++;
            $display("FAIL simultaneous flitv=%b credit=%0d required 1/3", flitv, credit_cnt);
        end
        tick();
    endtask

    task automatic test_deactivation();
        reqflit_t f;
        reqflit_t got[$];
        int gcyc[$];
        bit saw_deact;
        int n;
        f = mk_flit(8'h50);
        push(f);
        link_down = 1'b1;
        link_up = 1'b0;
        #1;
        checks++;
        if (req_in_ready !== 1'b0) begin
            failures++;
            $display("FAIL deact_ready ready=%b required=0", req_in_ready);
        end
        saw_deact = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (flitv) begin got.push_back(txreqflit); gcyc.push_back(c); end
            if (link_state == 2'd3 && txlinkactivereq == 1'b0) saw_deact = 1'b1;
        end
        checks++;
        if (got.size() != 3 || !saw_deact || credit_cnt !== 4'd0) begin
            failures++;
            $display("FAIL deact_summary flits=%0d saw_deact=%b credit=%0d required 3/1/0", got.size(), saw_deact, credit_cnt);
        end
        if (got.size() == 3) begin
            checks++;
            if (got[0] !== f || got[1] !== reqflit_t'('0) || got[2] !== reqflit_t'('0) || gcyc[2] != gcyc[1] + 1) begin
                failures++;
                $display("FAIL deact_flits f0=%h f1=%h f2=%h c1=%0d c2=%0d", got[0], got[1], got[2], gcyc[1], gcyc[2]);
            end
        end
        txlinkactiveack = 1'b0;
        n = 0;
        while (link_state != 2'd0 && n < 10) begin tick(); n++; end
        checks++;
        if ({link_state, credit_cnt, txlinkactivereq} !== {2'd0, 4'd0, 1'b0}) begin
            failures++;
            $display("FAIL deact_stop state=%0d credit=%0d req=%b required 0/0/0", link_state, credit_cnt, txlinkactivereq);
        end
    endtask

    task automatic test_reset_mid();
        logic [10:0] outs;
        bit stray;
        bring_up();
        for (int i = 0; i < 3; i++) push(mk_flit(8'(8'h60 + i)));
        lcrdv = 1'b1;
        tick();
        #2;
        reset = 1'b0;
        #1;
        outs = {txlinkactivereq, flitv, pend, credit_cnt, credit_overflow, link_state, req_in_ready};
        checks++;
        if (outs !== 11'd0 || txreqflit !== reqflit_t'('0)) begin
            failures++;
            $display("FAIL reset_async outs=%b flit=%h required 0", outs, txreqflit);
        end
        lcrdv = 1'b0;
        link_up = 1'b0;
        txlinkactiveack = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({link_state, flitv, credit_cnt} !== {2'd0, 1'b0, 4'd0}) begin
                failures++;
                $display("FAIL reset_release i=%0d state=%0d flitv=%b credit=%0d required 0/0/0", i, link_state, flitv, credit_cnt);
            end
        end
        bring_up();
        grant(1);
        stray = 1'b0;
        for (int i = 0; i < 4; i++) begin tick(); if (flitv) stray = 1'b1; end
        checks++;
        if (stray || credit_cnt !== 4'd1) begin
            failures++;
            $display("FAIL reset_discard stray=%b credit=%0d required 0/1", stray, credit_cnt);
        end
    endtask

    task automatic test_saturation();
        reqflit_t f;
        grant(14);
        checks++;
        if ({credit_cnt, credit_overflow} !== {4'd15, 1'b0}) begin
            failures++;
            $display("FAIL sat_fill credit=%0d ovf=%b required 15/0", credit_cnt, credit_overflow);
        end
        grant(1);
        checks++;
        if ({credit_cnt, credit_overflow} !== {4'd15, 1'b1}) begin
            failures++;
            $display("FAIL sat_overflow credit=%0d ovf=%b required 15/1", credit_cnt, credit_overflow);
        end
        f = mk_flit(8'h70);
        push(f);
        tick();
        checks++;
        if ({flitv, credit_cnt, credit_overflow} !== {1'b1, 4'd14, 1'b1} || txreqflit !== f) begin
            failures++;
            $display("FAIL sat_sticky flitv=%b credit=%0d ovf=%b required 1/14/1", flitv, credit_cnt, credit_overflow);
        end
    endtask

    task automatic test_random();
        reqflit_t exp_q[$];
        reqflit_t f;
        int m_credit, stall, lc_div;
        bit m_ovf, acc, lc, pp;
        m_credit = 14;
        m_ovf = 1'b1;
        stall = 0;
        for (int cyc = 0; cyc < 900; cyc++) begin
            f = mk_flit(8'($urandom));
            lc_div = ((cyc / 100) % 2 == 1) ? 1 : 4;
            req_in = f;
            req_in_valid = (cyc < 840) && ($urandom_range(0, 3) != 0);
            lcrdv = (cyc >= 840) || ($urandom_range(0, lc_div) == 0);
            #1;
            checks++;
            if (req_in_ready !== (exp_q.size() < DEPTH)) begin
                failures++;
                $display("FAIL rnd_ready cyc=%0d ready=%b queued=%0d", cyc, req_in_ready, exp_q.size());
            end
            acc = req_in_valid && (exp_q.size() < DEPTH);
            lc = lcrdv;
            pp = pend;
            tick();
            if (flitv) begin
                checks++;
                if (!pp || m_credit == 0 || exp_q.size() == 0 || txreqflit !== exp_q[0]) begin
                    failures++;
                    $display("FAIL rnd_flit cyc=%0d prev_pend=%b credit=%0d queued=%0d got=%h", cyc, pp, m_credit, exp_q.size(), txreqflit);
                end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (acc) exp_q.push_back(f);
            if (lc && !flitv) begin
                if (m_credit == 15) m_ovf = 1'b1;
                else m_credit++;
            end else if (!lc && flitv && m_credit > 0) begin
                m_credit--;
            end
            checks++;
            if (credit_cnt !== 4'(m_credit) || credit_overflow !== m_ovf) begin
                failures++;
                $display("FAIL rnd_credit cyc=%0d credit=%0d ovf=%b required %0d/%b", cyc, credit_cnt, credit_overflow, m_credit, m_ovf);
            end
            if (flitv || exp_q.size() == 0 || m_credit == 0) stall = 0;
            else stall++;
            checks++;
            if (stall > 2) begin
                failures++;
                $display("FAIL rnd_stall cyc=%0d stalled=%0d queued=%0d credit=%0d", cyc, stall, exp_q.size(), m_credit);
            end
        end
        req_in_valid = 1'b0;
        lcrdv = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL rnd_drain queued=%0d required=0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_activation();
        test_credit_gating();
        test_streaming();
        test_simultaneous();
        test_deactivation();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
